// File: rtl/alu_stage_pkg.sv
// Shared types and flag bit positions for the ALU result stage.
package alu_stage_pkg;

    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic v;
    } alu_flags_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } stage_state_t;

    localparam int unsigned FLAG_N = 3;
    localparam int unsigned FLAG_Z = 2;
    localparam int unsigned FLAG_C = 1;
    localparam int unsigned FLAG_V = 0;

endpackage

// File: rtl/alu_skid_buffer.sv
// Two-entry registered skid buffer holding {result, N, Z, C, V} per entry.
module alu_skid_buffer
    import alu_stage_pkg::*;
#(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W+3:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W+3:0] out_data
);

    stage_state_t r_state;
    logic [W+3:0] r_head;
    logic [W+3:0] r_tail;
    logic         w_accept;
    logic         w_pop;

    // Ready is a function of state only, so downstream ready never reaches upstream.
    assign in_ready  = rst_n && (r_state != TWO);
    assign out_valid = (r_state != EMPTY);
    assign out_data  = r_head;
    assign w_accept  = in_valid && in_ready;
    assign w_pop     = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= EMPTY;
            r_head  <= '0;
            r_tail  <= '0;
        end else begin
            case (r_state)
                EMPTY: begin
                    if (w_accept) begin
                        r_head  <= in_data;
                        r_state <= ONE;
                    end
                end
                ONE: begin
                    if (w_accept && w_pop) begin
                        r_head <= in_data;
                    end else if (w_accept) begin
                        r_tail  <= in_data;
                        r_state <= TWO;
                    end else if (w_pop) begin
                        r_state <= EMPTY;
                    end
                end
                TWO: begin
                    if (w_pop) begin
                        r_head  <= r_tail;
                        r_state <= ONE;
                    end
                end
                default: r_state <= EMPTY;
            endcase
        end
    end

endmodule

// File: rtl/alu_result_stage.sv
// Registered ALU result stage: skid-buffered output, status flags, carry feedback.
// Optional ALU_STICKY_OVF_EN adds a sticky overflow output.
module alu_result_stage
    import alu_stage_pkg::*;
#(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_result,
    input  logic         in_negative,
    input  logic         in_zero,
    input  logic         in_carry,
    input  logic         in_overflow,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_result,
    output logic [3:0]   out_flags,
    output logic [3:0]   status_flags,
    output logic         carry_fb,
    input  logic         flags_clear
`ifdef ALU_STICKY_OVF_EN
   ,output logic         sticky_ovf
`endif
);

    logic [W+3:0] w_in_data;
    logic [W+3:0] w_out_data;
    logic         w_accept;
    alu_flags_t   w_in_flags;
    alu_flags_t   r_status;

    assign w_in_flags = '{n: in_negative, z: in_zero, c: in_carry, v: in_overflow};
    assign w_in_data  = {in_result, w_in_flags};
    assign w_accept   = in_valid && in_ready;

    alu_skid_buffer #(.W(W)) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (w_in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (w_out_data)
    );

    assign out_result = w_out_data[W+3:4];
    assign out_flags  = w_out_data[3:0];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_status <= '0;
        end else if (w_accept) begin
            r_status <= w_in_flags;
        end else if (flags_clear) begin
            r_status <= '0;
        end
    end

    assign status_flags = r_status;
    assign carry_fb     = status_flags[FLAG_C];

`ifdef ALU_STICKY_OVF_EN
    logic r_sticky_ovf;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sticky_ovf <= 1'b0;
        end else if (w_accept && in_overflow) begin
            r_sticky_ovf <= 1'b1;
        end else if (flags_clear) begin
            r_sticky_ovf <= 1'b0;
        end
    end

    assign sticky_ovf = r_sticky_ovf;
`endif

endmodule
